// File: rtl/beacon_nav_fsm.sv
// Beacon-homing navigation controller: debounces three detector codes, steers toward
// the target beacon, inserts coast dead-time on direction reversals and latches overcurrent faults.
module beacon_nav_fsm #(
    parameter int DEBOUNCE_CYCLES   = 100000,
    parameter int DEADTIME_CYCLES   = 50000,
    parameter int FAULT_HOLD_CYCLES = 50000000,
    parameter int SEARCH_TIMEOUT    = 500000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic [1:0] target_id,
    input  logic [1:0] forward_signal,
    input  logic [1:0] left_signal,
    input  logic [1:0] right_signal,
    input  logic       compA,
    input  logic       compB,
    output logic [3:0] direction,
    output logic [2:0] speed,
    output logic [2:0] nav_state,
    output logic       fault,
    output logic       timed_out
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DT_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam int FH_W = (FAULT_HOLD_CYCLES > 1) ? $clog2(FAULT_HOLD_CYCLES) : 1;
    localparam int ST_W = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;

    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CYCLES - 1);
    localparam logic [FH_W-1:0] FH_LAST = FH_W'(FAULT_HOLD_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SEARCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        FWD    = 3'd2,
        LEFT   = 3'd3,
        RIGHT  = 3'd4,
        FAULT  = 3'd5
    } state_t;

    state_t state, next_state;

    logic            go_s1, go_s2;
    logic [1:0]      comp_s1, comp_s2;
    logic [2:0][1:0] raw, sig_s1, sig_s2, cand, filt;
    logic [2:0][DB_W-1:0] db_cnt;
    logic            oc, hit_f, hit_l, hit_r, set_timeout;
    logic [ST_W-1:0] search_cnt;
    logic [FH_W-1:0] fault_cnt;
    logic [3:0]      cmd_dir, dt_target;
    logic [2:0]      cmd_speed;
    logic            dt_active;
    logic [DT_W-1:0] dt_cnt;

    assign raw[0] = forward_signal;
    assign raw[1] = left_signal;
    assign raw[2] = right_signal;

    // Channel 0 = forward, 1 = left, 2 = right; a change restarts the stability count at one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            go_s1   <= 1'b0;
            go_s2   <= 1'b0;
            comp_s1 <= '0;
            comp_s2 <= '0;
            sig_s1  <= '0;
            sig_s2  <= '0;
            cand    <= '0;
            filt    <= '0;
            db_cnt  <= '0;
        end else begin
            go_s1   <= go;
            go_s2   <= go_s1;
            comp_s1 <= {compB, compA};
            comp_s2 <= comp_s1;
            sig_s1  <= raw;
            sig_s2  <= sig_s1;
            for (int i = 0; i < 3; i++) begin
                if (sig_s2[i] != cand[i]) begin
                    cand[i]   <= sig_s2[i];
                    db_cnt[i] <= DB_W'(1);
                end else begin
                    if (db_cnt[i] != DB_MAX)
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    if (db_cnt[i] >= DB_LAST)
                        filt[i] <= cand[i];
                end
            end
        end
    end

    assign oc    = comp_s2[0] | comp_s2[1];
    assign hit_f = (filt[0] == target_id) && (target_id != 2'd0);
    assign hit_l = (filt[1] == target_id) && (target_id != 2'd0);
    assign hit_r = (filt[2] == target_id) && (target_id != 2'd0);

    always_comb begin
        next_state  = state;
        set_timeout = 1'b0;
        case (state)
            IDLE:  if (go_s2 && !timed_out) next_state = SEARCH;
            FAULT: if (fault_cnt == FH_LAST && !oc) next_state = go_s2 ? SEARCH : IDLE;
            default: begin
                if (oc)          next_state = FAULT;
                else if (!go_s2) next_state = IDLE;
                else if (hit_f)  next_state = FWD;
                else if (hit_l)  next_state = LEFT;
                else if (hit_r)  next_state = RIGHT;
                else if (state == SEARCH && search_cnt == ST_LAST) begin
                    next_state  = IDLE;
                    set_timeout = 1'b1;
                end else         next_state = SEARCH;
            end
        endcase
    end

    always_comb begin
        cmd_dir   = 4'b0000;
        cmd_speed = 3'd0;
        case (state)
            SEARCH: begin cmd_dir = 4'b0110; cmd_speed = 3'd3; end
            FWD:    begin cmd_dir = 4'b1010; cmd_speed = 3'd7; end
            LEFT:   begin cmd_dir = 4'b0110; cmd_speed = 3'd4; end
            RIGHT:  begin cmd_dir = 4'b1001; cmd_speed = 3'd4; end
            default: ;
        endcase
    end

    // Both timers restart whenever their state is (re)entered and saturate at their limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timed_out  <= 1'b0;
            search_cnt <= '0;
            fault_cnt  <= '0;
        end else begin
            state <= next_state;
            if (!go_s2)           timed_out <= 1'b0;
            else if (set_timeout) timed_out <= 1'b1;
            if (state != SEARCH)          search_cnt <= '0;
            else if (search_cnt != ST_LAST) search_cnt <= search_cnt + ST_W'(1);
            if (state != FAULT)           fault_cnt <= '0;
            else if (fault_cnt != FH_LAST)  fault_cnt <= fault_cnt + FH_W'(1);
        end
    end

    // A change between two different non-zero words coasts first; stopping is always immediate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            direction <= 4'b0000;
            speed     <= 3'd0;
            dt_active <= 1'b0;
            dt_target <= 4'b0000;
            dt_cnt    <= '0;
        end else if (cmd_dir == 4'b0000) begin
            direction <= 4'b0000;
            speed     <= 3'd0;
            dt_active <= 1'b0;
            dt_cnt    <= '0;
        end else if (dt_active) begin
            if (cmd_dir != dt_target) begin
                dt_target <= cmd_dir;
                dt_cnt    <= '0;
            end else if (dt_cnt == DT_LAST) begin
                direction <= dt_target;
                speed     <= cmd_speed;
                dt_active <= 1'b0;
            end else begin
                dt_cnt <= dt_cnt + DT_W'(1);
            end
        end else if (direction == 4'b0000 || cmd_dir == direction) begin
            direction <= cmd_dir;
            speed     <= cmd_speed;
        end else begin
            direction <= 4'b0000;
            speed     <= 3'd0;
            dt_target <= cmd_dir;
            dt_cnt    <= '0;
            dt_active <= 1'b1;
        end
    end

    assign nav_state = state;
    assign fault     = (state == FAULT);

endmodule

// File: doc/beacon_nav_fsm.md
Name: beacon_nav_fsm

Overview:
Navigation controller between the frequency signal detection stage and the motor driver / PWM stages. It consumes the three 2-bit beacon codes (forward, left, right), debounces them, and steers the rover with a state machine toward the beacon whose code matches target_id. It produces the 4-bit H-bridge direction word and the 3-bit speed code. It forces a coast dead-time on every direction change and latches an overcurrent fault from compA/compB.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive stable cycles before a beacon code is accepted (1 ms at 100 MHz)
DEADTIME_CYCLES, 50000, coast cycles inserted between two different non-zero direction words
FAULT_HOLD_CYCLES, 50000000, minimum time in FAULT
SEARCH_TIMEOUT, 500000000, maximum cycles in SEARCH before giving up

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
go  in  1  run enable (switch, level)
target_id  in  2  beacon code to home on; 0 = none
forward_signal  in  2  raw code, forward detector (0 = nothing)
left_signal  in  2  raw code, left detector
right_signal  in  2  raw code, right detector
compA  in  1  motor A overcurrent, active-high
compB  in  1  motor B overcurrent, active-high
direction  out  4  {A_fwd, A_rev, B_fwd, B_rev} to motor driver
speed  out  3  speed code to PWM
nav_state  out  3  state encoding, for 7-seg/LEDs
fault  out  1  high while in FAULT
timed_out  out  1  high after a search timeout until go is deasserted

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, direction 0000, speed 0, nav_state 0, fault 0, timed_out 0, all counters 0, all filtered codes 00.
- Synchronisers: go, compA, compB, and all signal codes pass through two flops. The overcurrent signal oc is sync(compA) OR sync(compB).
- Debounce, per channel: a counter resets whenever the synced raw value changes. When the raw value has held for DEBOUNCE_CYCLES consecutive cycles, the filtered value takes the raw value. Any pulse shorter than that is never seen.
- Hits: hit_x = (filtered_x == target_id) and (target_id != 0). Priority is forward > left > right.
- States and encodings: IDLE=0, SEARCH=1, FWD=2, LEFT=3, RIGHT=4, FAULT=5.
- Commanded direction and speed per state:
  - IDLE: 0000, speed 0.
  - SEARCH: 0110 (spin left), speed 3.
  - FWD: 1010, speed 7.
  - LEFT: 0110, speed 4.
  - RIGHT: 1001, speed 4.
  - FAULT: 0000, speed 0.
- Transitions are evaluated every cycle, highest priority first:
  1. From any state other than IDLE and FAULT, oc=1 → FAULT. The fault hold counter is cleared.
  2. From SEARCH, FWD, LEFT or RIGHT, go=0 → IDLE.
  3. IDLE with go=1 and timed_out=0 → SEARCH.
  4. From SEARCH, FWD, LEFT or RIGHT:
     - hit_f → FWD
     - else hit_l → LEFT
     - else hit_r → RIGHT
     - else → SEARCH.
  5. SEARCH timer: clears on entry to SEARCH and counts only while in SEARCH. When it reaches SEARCH_TIMEOUT-1: → IDLE and set timed_out.
  6. FAULT exit: after FAULT_HOLD_CYCLES have elapsed and oc=0:
     - go=1 → SEARCH
     - go=0 → IDLE.
     While oc stays high, the block remains in FAULT.
- timed_out clears when go is 0. It blocks IDLE→SEARCH until go falls and rises again.
- Output stage:
  - direction and speed are registered and lag the state change by one cycle.
  - If the new commanded direction is non-zero, differs from the current non-zero output, and is not a simple switch to 0000: output 0000 and speed 0 for DEADTIME_CYCLES, then apply the new command.
  - Transitions to 0000 are applied immediately.
  - A re-command during dead-time restarts the dead-time only if the target word changes.
- FAULT and IDLE override any dead-time in progress: the output becomes 0000 on the next cycle.
- Counters saturate and do not wrap. Each counter has the minimum width for its parameter.

Test Plan (params: DEBOUNCE=4, DEADTIME=3, FAULT_HOLD=10, SEARCH_TIMEOUT=50):
1. Assert reset mid-operation in the FWD state → direction=0000, speed=0, nav_state=0 in the same cycle (asynchronous). After release with go=1 → nav_state=1, direction 0110, speed 3.
2. target_id=2, go=1, forward_signal=2 held → nav_state=2 after 2 sync + 4 debounce cycles. Direction goes 0000 for 3 cycles, then 1010 with speed 7.
3. forward_signal=2 pulsed for 3 cycles while in SEARCH → state stays 1 and direction stays 0110.
4. left_signal=2 then right_signal=2 with left dropped → LEFT (0110), then 3 cycles of 0000, then RIGHT (1001), speed 4. A simultaneous forward hit overrides both → FWD.
5. compA high 2 cycles in FWD → fault=1, direction=0000. Check the exit scenario:
   - Exit occurs only after 10 cycles.
   - With compB held high past the hold, the block stays in FAULT.
   - On release with go=1 → SEARCH.
6. No hits for 50 cycles in SEARCH → nav_state=0, timed_out=1. go held high, so the block remains IDLE. Toggle go 0→1 → timed_out=0 and SEARCH.
